fifo_wr_arbiter: RTL and testbench
==================================

// Module: fifo_wr_arbiter
// PURPOSE
//   Round-robin arbiter that shares the single write port of the synchronous FIFO between
//   NUM_REQ producers. Each producer offers data with a valid/ready handshake. The arbiter
//   grants one producer at a time for a bounded burst and drives the FIFO wr_en/wdata.
//   It respects the FIFO full flag, so it never attempts an overflow write.
// PARAMETERS
//   DATA_WIDTH  8   width of each producer word and of FIFO wdata
//   NUM_REQ     4   number of producers (>=2)
//   MAX_BURST   4   max beats accepted from one owner per grant (>=1)
// PORTS
//   clk          in   1                   single clock, rising edge
//   rst_n        in   1                   asynchronous, active-low reset
//   req_valid    in   NUM_REQ             producer i has a word on req_data[i]
//   req_data     in   NUM_REQ*DATA_WIDTH  packed; word i = bits [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready    out  NUM_REQ             word i is accepted this cycle when valid&ready
//   fifo_wr_en   out  1                   to FIFO wr_en
//   fifo_wdata   out  DATA_WIDTH          to FIFO wdata
//   fifo_full    in   1                   from FIFO full
//   grant_id     out  $clog2(NUM_REQ)     current owner index (valid when busy=1)
//   busy         out  1                   a grant is active
// BEHAVIOUR
//   - Reset (async assert, sync release): state=IDLE, rr_ptr=0, owner=0, beat_cnt=0.
//     All outputs are 0: req_ready, fifo_wr_en, fifo_wdata, grant_id, busy.
//   - FSM states: IDLE, GRANT.
//   - IDLE: if any req_valid is set, owner <= first i with req_valid[i], searched cyclically
//     starting at rr_ptr. Then go to GRANT, beat_cnt <= 0.
//     Arbitration takes 1 cycle. No word is accepted in IDLE.
//   - GRANT:
//     - req_ready[owner] = !fifo_full. All other req_ready bits are 0.
//     - fifo_wr_en = req_valid[owner] & req_ready[owner], combinational, same cycle.
//     - fifo_wdata = req_data[owner] while in GRANT; holds its last value otherwise.
//     - Each beat (wr_en=1) increments beat_cnt.
//   - Release from GRANT back to IDLE, with rr_ptr <= owner+1 (mod NUM_REQ), when either:
//     (a) a beat occurs with beat_cnt==MAX_BURST-1, or
//     (b) req_valid[owner]==0 at a cycle edge.
//     Releasing costs one idle bubble cycle before the next grant.
//   - fifo_full in GRANT: ready=0, no beat, beat_cnt and owner frozen. The grant is held
//     until full drops. A full stall never counts as release condition (b) while valid is held.
//   - Producer contract: once req_valid is asserted it must stay high, with data stable,
//     until accepted. The arbiter does not check this.
//   - Full and valid asserted together at the same edge: no write. FIFO never sees
//     wr_en=1 with full=1.
//   - rr_ptr wrap-around: the index after NUM_REQ-1 is 0.
//   - Single requester continuously valid: it is re-granted after each bubble, giving
//     MAX_BURST beats per MAX_BURST+1 cycles.
//   - Reset mid-burst: outputs drop to 0 immediately (async). A partial burst is abandoned;
//     the words already written stay in the FIFO.
// STRUCTURE
//   - Shared package fifo_pkg: arb_state_e {IDLE, GRANT}, plus the default-width localparams
//     shared with the FIFO and its interface.
//   - One sub-module rr_pick: combinational cyclic priority encoder.
//     Inputs: req vector, start pointer. Outputs: index, any.
//   - Everything else is inline: FSM, counters, data mux.
// TESTING
//   Bench connects to fifo (DATA_WIDTH=8, FIFO_DEPTH=16); assertion never (fifo_wr_en && fifo_full).
//   1 Only req0 valid with data 0x10..0x17, MAX_BURST=4:
//     -> two bursts 0x10-13 then 0x14-17, one bubble between them, FIFO reads back in order.
//   2 All 4 valid continuously, each streams its own tag (0xA0+i):
//     -> grant order 0,1,2,3,0; each burst is exactly 4 beats.
//   3 FIFO pre-filled with 15 words, req2 valid:
//     -> 1 beat, full=1, ready2=0 and grant held, then 1 read, then the next beat is accepted.
//   4 req1 valid for 2 beats, then drops:
//     -> release after 2 beats, rr_ptr=2; req3 and req0 both valid -> req3 wins.
//   5 rst_n low in the middle of a burst after beat 2:
//     -> wr_en, ready, busy are 0 in the same cycle; after release, grant restarts from req0.
//   6 Owner is 3 and releases; req0 is the only one valid:
//     -> rr_ptr wraps to 0 and req0 is granted.

Source files
------------

// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : fifo_pkg
//  Description : Types and default widths shared by the synchronous FIFO,
//                its write-port arbiter and their benches.
//  Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    // Write-port arbiter states: IDLE arbitrates, GRANT streams from one owner.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    localparam int c_DEF_DATA_WIDTH = 8;
    localparam int c_DEF_FIFO_DEPTH = 16;
    localparam int c_DEF_NUM_REQ    = 4;
    localparam int c_DEF_MAX_BURST  = 4;

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational cyclic priority encoder. Returns the first set
//                bit of i_req found when scanning upward from i_start and
//                wrapping past NUM_REQ-1 back to 0.
//  Ports       : i_req   [NUM_REQ]        request vector
//                i_start [$clog2(NUM_REQ)] index searched first
//                o_idx   [$clog2(NUM_REQ)] winning index (0 when none)
//                o_any   [1]               at least one request set
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
    import fifo_pkg::*;
#(
    parameter int NUM_REQ = c_DEF_NUM_REQ
) (
    input  logic [NUM_REQ-1:0]         i_req,
    input  logic [$clog2(NUM_REQ)-1:0] i_start,
    output logic [$clog2(NUM_REQ)-1:0] o_idx,
    output logic                       o_any
);

    localparam int c_IDW = $clog2(NUM_REQ);
    localparam int c_SW  = c_IDW + 1;

    logic [c_SW-1:0] w_pos;

    // Offsets are scanned from the farthest to the nearest so that the
    // nearest set request (smallest cyclic distance from i_start) is the
    // last one written and therefore wins.
    always_comb begin
        o_idx = '0;
        o_any = 1'b0;
        w_pos = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_pos = {1'b0, i_start} + c_SW'(k);
            if (w_pos >= c_SW'(NUM_REQ)) begin
                w_pos = w_pos - c_SW'(NUM_REQ);
            end
            if (i_req[w_pos[c_IDW-1:0]]) begin
                o_idx = w_pos[c_IDW-1:0];
                o_any = 1'b1;
            end
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_wr_arbiter
//  Description : Round-robin arbiter sharing the single write port of a
//                synchronous FIFO between NUM_REQ valid/ready producers.
//                One producer owns the port for up to MAX_BURST beats, then
//                the port is released (one idle bubble) and re-arbitrated
//                starting after the previous owner. Writes are suppressed
//                whenever the FIFO reports full.
//  Ports       : clk         clock, rising edge
//                rst_n       asynchronous active-low reset
//                req_valid   [NUM_REQ]            producer word offered
//                req_data    [NUM_REQ*DATA_WIDTH] packed producer words
//                req_ready   [NUM_REQ]            producer word accepted
//                fifo_wr_en  FIFO write enable
//                fifo_wdata  [DATA_WIDTH] FIFO write data
//                fifo_full   FIFO full flag
//                grant_id    [$clog2(NUM_REQ)] current owner (valid with busy)
//                busy        a grant is active
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = c_DEF_DATA_WIDTH,
    parameter int NUM_REQ    = c_DEF_NUM_REQ,
    parameter int MAX_BURST  = c_DEF_MAX_BURST
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_wdata,
    input  logic                          fifo_full,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy
);

    localparam int c_IDW = $clog2(NUM_REQ);
    localparam int c_BCW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [c_BCW-1:0] c_LAST_BEAT = c_BCW'(MAX_BURST - 1);
    localparam logic [c_IDW-1:0] c_LAST_ID   = c_IDW'(NUM_REQ - 1);

    arb_state_e             r_state;
    arb_state_e             w_state_nxt;
    logic [c_IDW-1:0]       r_owner;
    logic [c_IDW-1:0]       w_owner_nxt;
    logic [c_IDW-1:0]       r_rr_ptr;
    logic [c_IDW-1:0]       w_rr_ptr_nxt;
    logic [c_BCW-1:0]       r_beat_cnt;
    logic [c_BCW-1:0]       w_beat_cnt_nxt;
    logic [DATA_WIDTH-1:0]  r_wdata;
    logic [DATA_WIDTH-1:0]  w_wdata_nxt;

    logic [c_IDW-1:0]       w_pick_idx;
    logic                   w_pick_any;
    logic [DATA_WIDTH-1:0]  w_owner_data;
    logic [c_IDW-1:0]       w_owner_inc;
    logic [NUM_REQ-1:0]     w_ready;
    logic                   w_wr_en;
    logic                   w_busy;
    logic [DATA_WIDTH-1:0]  w_wdata_out;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .i_req   (req_valid),
        .i_start (r_rr_ptr),
        .o_idx   (w_pick_idx),
        .o_any   (w_pick_any)
    );

    assign w_owner_data = req_data[r_owner*DATA_WIDTH +: DATA_WIDTH];

    // Explicit wrap so non-power-of-two NUM_REQ also returns to 0.
    assign w_owner_inc = (r_owner == c_LAST_ID) ? '0 : r_owner + c_IDW'(1);

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_owner    <= '0;
            r_rr_ptr   <= '0;
            r_beat_cnt <= '0;
            r_wdata    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_owner    <= w_owner_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
            r_wdata    <= w_wdata_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_owner_nxt    = r_owner;
        w_rr_ptr_nxt   = r_rr_ptr;
        w_beat_cnt_nxt = r_beat_cnt;
        w_wdata_nxt    = r_wdata;
        w_ready        = '0;
        w_wr_en        = 1'b0;
        w_busy         = 1'b0;
        w_wdata_out    = r_wdata;

        case (r_state)
            IDLE: begin
                if (w_pick_any) begin
                    w_owner_nxt    = w_pick_idx;
                    w_beat_cnt_nxt = '0;
                    w_state_nxt    = GRANT;
                end
            end

            GRANT: begin
                w_busy           = 1'b1;
                w_ready[r_owner] = !fifo_full;
                w_wr_en          = req_valid[r_owner] & !fifo_full;
                w_wdata_out      = w_owner_data;
                // Track the mux so wdata holds the last granted word after release.
                w_wdata_nxt      = w_owner_data;

                if (w_wr_en) begin
                    w_beat_cnt_nxt = r_beat_cnt + c_BCW'(1);
                end

                // A full stall with valid held matches neither term, so the
                // grant (and beat count) simply freeze until full drops.
                if ((w_wr_en && (r_beat_cnt == c_LAST_BEAT)) || !req_valid[r_owner]) begin
                    w_state_nxt  = IDLE;
                    w_rr_ptr_nxt = w_owner_inc;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign req_ready  = w_ready;
    assign fifo_wr_en = w_wr_en;
    assign fifo_wdata = w_wdata_out;
    assign grant_id   = r_owner;
    assign busy       = w_busy;

endmodule : fifo_wr_arbiter
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_wr_arbiter
//  Description : Bench for fifo_wr_arbiter with a 16-deep FIFO model, queue
//                based producers and a transaction-level arbiter model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arbiter;
    import fifo_pkg::*;

    localparam int DW    = 8;
    localparam int NR    = 4;
    localparam int MB    = 4;
    localparam int DEPTH = c_DEF_FIFO_DEPTH;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NR-1:0]    req_valid;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]    req_ready;
    logic             fifo_wr_en;
    logic [DW-1:0]    fifo_wdata;
    logic             fifo_full;
    logic [1:0]       grant_id;
    logic             busy;

    fifo_wr_arbiter #(
        .DATA_WIDTH (DW),
        .NUM_REQ    (NR),
        .MAX_BURST  (MB)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .fifo_wr_en (fifo_wr_en),
        .fifo_wdata (fifo_wdata),
        .fifo_full  (fifo_full),
        .grant_id   (grant_id),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // producers: ring buffers of pending words
    logic [7:0] pbuf [NR][64];
    int         phead [NR];
    int         ptail [NR];

    // FIFO contents (what the DUT wrote) and what the model says it should hold
    logic [7:0] fifo_q [$];
    logic [7:0] exp_q  [$];
    bit         do_read;

    // reference model of the arbiter
    bit         m_busy;
    int         m_owner, m_ptr, m_beats;
    logic [7:0] m_wdata;

    // per-cycle samples and observation logs
    logic [3:0] s_ready;
    logic       s_wr, s_busy, s_prev_busy;
    logic [7:0] s_wdata;
    logic [1:0] s_grant;
    int         g_log [$];
    int         b_log [$];
    int         bcnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pcount(input int p);
        return ptail[p] - phead[p];
    endfunction

    function automatic int glog(input int k);
        return (g_log.size() > k) ? g_log[k] : -1;
    endfunction

    function automatic int blog(input int k);
        return (b_log.size() > k) ? b_log[k] : -1;
    endfunction

    task automatic push_word(input int p, input logic [7:0] w);
        pbuf[p][ptail[p] % 64] = w;
        ptail[p]++;
    endtask

    task automatic drive_inputs();
        for (int p = 0; p < NR; p++) begin
            if (pcount(p) > 0) begin
                req_valid[p]          = 1'b1;
                req_data[p*DW +: DW]  = pbuf[p][phead[p] % 64];
            end else begin
                req_valid[p]          = 1'b0;
                req_data[p*DW +: DW]  = 8'($urandom);
            end
        end
        fifo_full = (fifo_q.size() >= DEPTH);
    endtask

    task automatic m_reset();
        m_busy  = 1'b0;
        m_owner = 0;
        m_ptr   = 0;
        m_beats = 0;
        m_wdata = 8'h00;
    endtask

    // One clock: compare at the falling edge, advance model/environment
    // just after the rising edge.
    task automatic cycle();
        logic [3:0] e_ready;
        logic       e_wr;
        logic [7:0] e_wdata;
        bit         found;
        logic [7:0] a, e;

        @(negedge clk);
        if (m_busy) begin
            e_ready = fifo_full ? 4'b0000 : 4'(1 << m_owner);
            e_wr    = req_valid[m_owner] & ~fifo_full;
            e_wdata = req_data[m_owner*DW +: DW];
        end else begin
            e_ready = 4'b0000;
            e_wr    = 1'b0;
            e_wdata = m_wdata;
        end
        chk("req_ready", 32'(req_ready), 32'(e_ready));
        chk("fifo_wr_en", 32'(fifo_wr_en), 32'(e_wr));
        chk("fifo_wdata", 32'(fifo_wdata), 32'(e_wdata));
        chk("busy", 32'(busy), 32'(m_busy));
        if (m_busy) chk("grant_id", 32'(grant_id), 32'(m_owner));
        chk("no_write_when_full", 32'(fifo_wr_en & fifo_full), 32'd0);

        s_ready = req_ready;
        s_wr    = fifo_wr_en;
        s_busy  = busy;
        s_wdata = fifo_wdata;
        s_grant = grant_id;
        if (busy && !s_prev_busy) begin
            g_log.push_back(int'(grant_id));
            bcnt = 0;
        end
        if (busy && fifo_wr_en) bcnt++;
        if (!busy && s_prev_busy) b_log.push_back(bcnt);
        s_prev_busy = busy;

        @(posedge clk);
        #1;
        if (rst_n) begin
            if (!m_busy) begin
                if (req_valid != 4'b0000) begin
                    found = 1'b0;
                    for (int k = 0; k < NR; k++) begin
                        int j;
                        j = (m_ptr + k) % NR;
                        if (!found && req_valid[j]) begin
                            m_owner = j;
                            found   = 1'b1;
                        end
                    end
                    m_busy  = 1'b1;
                    m_beats = 0;
                end
            end else begin
                m_wdata = req_data[m_owner*DW +: DW];
                if (e_wr) m_beats++;
                if ((e_wr && m_beats == MB) || !req_valid[m_owner]) begin
                    m_busy = 1'b0;
                    m_ptr  = (m_owner + 1) % NR;
                end
            end
        end
        for (int p = 0; p < NR; p++) begin
            if (req_valid[p] && s_ready[p]) phead[p]++;
        end
        if (do_read && fifo_q.size() > 0) begin
            a = fifo_q.pop_front();
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            chk("fifo_readback", 32'(a), 32'(e));
        end
        if (s_wr) fifo_q.push_back(s_wdata);
        if (e_wr) exp_q.push_back(e_wdata);
        drive_inputs();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        m_reset();
        for (int p = 0; p < NR; p++) begin
            phead[p] = 0;
            ptail[p] = 0;
        end
        fifo_q.delete();
        exp_q.delete();
        do_read = 1'b0;
        drive_inputs();
        #1;
        chk("reset_outputs", 32'({req_ready, fifo_wr_en, fifo_wdata, grant_id, busy}), 32'd0);
        cycle();
        cycle();
        rst_n = 1'b1;
        g_log.delete();
        b_log.delete();
        bcnt        = 0;
        s_prev_busy = 1'b0;
    endtask

    initial begin
        int         c;
        logic [9:0] hist;

        rst_n     = 1'b1;
        req_valid = '0;
        req_data  = '0;
        fifo_full = 1'b0;
        m_reset();
        #2;

        // ---- 1: single producer, two bursts with one bubble ----
        do_reset();
        for (int k = 0; k < 8; k++) push_word(0, 8'h10 + 8'(k));
        drive_inputs();
        c = 0;
        hist = '0;
        while (pcount(0) > 0 && c < 40) begin
            cycle();
            hist = {hist[8:0], s_wr};
            c++;
        end
        chk("t1_cycles", 32'(c), 32'd10);
        chk("t1_wr_pattern", 32'(hist), 32'(10'b0111101111));
        cycle();
        chk("t1_fifo_count", 32'(fifo_q.size()), 32'd8);
        for (int k = 0; k < 8; k++) begin
            logic [7:0] w;
            w = (fifo_q.size() > k) ? fifo_q[k] : 8'hxx;
            chk("t1_fifo_order", 32'(w), 32'(8'h10 + 8'(k)));
        end

        // ---- 2: all four streaming, round-robin order and burst length ----
        do_reset();
        for (int p = 0; p < NR; p++)
            for (int k = 0; k < 8; k++) push_word(p, 8'hA0 + 8'(p));
        do_read = 1'b1;
        drive_inputs();
        c = 0;
        while (g_log.size() < 6 && c < 80) begin
            cycle();
            c++;
        end
        chk("t2_grant0", 32'(glog(0)), 32'd0);
        chk("t2_grant1", 32'(glog(1)), 32'd1);
        chk("t2_grant2", 32'(glog(2)), 32'd2);
        chk("t2_grant3", 32'(glog(3)), 32'd3);
        chk("t2_grant4", 32'(glog(4)), 32'd0);
        for (int k = 0; k < 5; k++) chk("t2_burst_len", 32'(blog(k)), 32'd4);

        // ---- 3: FIFO near full, grant held through a full stall ----
        do_reset();
        for (int k = 0; k < 15; k++) begin
            fifo_q.push_back(8'(k));
            exp_q.push_back(8'(k));
        end
        for (int k = 0; k < 3; k++) push_word(2, 8'h30 + 8'(k));
        drive_inputs();
        cycle();
        cycle();
        chk("t3_first_beat", 32'(s_wr), 32'd1);
        chk("t3_first_data", 32'(s_wdata), 32'h30);
        cycle();
        chk("t3_full_ready", 32'(s_ready), 32'd0);
        chk("t3_full_wr", 32'(s_wr), 32'd0);
        chk("t3_full_busy", 32'(s_busy), 32'd1);
        chk("t3_full_grant", 32'(s_grant), 32'd2);
        do_read = 1'b1;
        cycle();
        do_read = 1'b0;
        chk("t3_held_grant", 32'(s_grant), 32'd2);
        cycle();
        chk("t3_resume_beat", 32'(s_wr), 32'd1);
        chk("t3_resume_data", 32'(s_wdata), 32'h31);

        // ---- 4: owner drops valid early, pointer moves past it ----
        do_reset();
        push_word(1, 8'h51);
        push_word(1, 8'h52);
        drive_inputs();
        cycle();
        push_word(0, 8'h40);
        push_word(3, 8'h43);
        drive_inputs();
        c = 0;
        while (g_log.size() < 3 && c < 40) begin
            cycle();
            c++;
        end
        chk("t4_grant_req1", 32'(glog(0)), 32'd1);
        chk("t4_burst_req1", 32'(blog(0)), 32'd2);
        chk("t4_req3_wins", 32'(glog(1)), 32'd3);
        chk("t4_then_req0", 32'(glog(2)), 32'd0);

        // ---- 5: reset in the middle of a burst ----
        do_reset();
        for (int k = 0; k < 8; k++) push_word(0, 8'h20 + 8'(k));
        drive_inputs();
        c = 0;
        while (fifo_q.size() < 2 && c < 20) begin
            cycle();
            c++;
        end
        rst_n = 1'b0;
        #1;
        chk("t5_rst_wr_en", 32'(fifo_wr_en), 32'd0);
        chk("t5_rst_ready", 32'(req_ready), 32'd0);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        m_reset();
        chk("t5_words_kept", 32'(fifo_q.size()), 32'd2);
        cycle();
        cycle();
        rst_n = 1'b1;
        g_log.delete();
        b_log.delete();
        s_prev_busy = 1'b0;
        push_word(1, 8'h61);
        drive_inputs();
        c = 0;
        while (g_log.size() < 1 && c < 10) begin
            cycle();
            c++;
        end
        chk("t5_restart_req0", 32'(glog(0)), 32'd0);

        // ---- 6: pointer wrap after owner 3 ----
        do_reset();
        push_word(3, 8'h73);
        drive_inputs();
        cycle();
        cycle();
        cycle();
        push_word(0, 8'h70);
        push_word(2, 8'h72);
        drive_inputs();
        c = 0;
        while (g_log.size() < 2 && c < 10) begin
            cycle();
            c++;
        end
        chk("t6_grant_req3", 32'(glog(0)), 32'd3);
        chk("t6_wrap_req0", 32'(glog(1)), 32'd0);

        // ---- random traffic against the model ----
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            for (int p = 0; p < NR; p++) begin
                if ($urandom_range(7) == 0 && pcount(p) < 6) push_word(p, 8'($urandom));
            end
            if (((i / 400) % 2) == 0) do_read = ($urandom_range(3) != 0);
            else                      do_read = ($urandom_range(3) == 0);
            drive_inputs();
            cycle();
        end
        do_read = 1'b1;
        for (int i = 0; i < 60; i++) cycle();
        chk("random_drain_empty", 32'(fifo_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_fifo_wr_arbiter
`default_nettype wire
